// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile -- 32 x 32-bit register file with the writeback mux built in.
//
// The MEM/WB stage value (load data or ALU result) is selected here and is
// also exported on wbdata so the forwarding muxes can use it. Two decode-stage
// read ports are combinational and see a same-cycle write through a bypass.
// Register 0 is hard-wired to zero. wb_count counts committed writes.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous reset, active low
//   readdata_WB  in  32   load data from MEM/WB
//   alu_WB       in  32   ALU result from MEM/WB
//   rd_WB        in   5   destination register index
//   memtoreg_WB  in   1   1 = write readdata_WB, 0 = write alu_WB
//   regwrite_WB  in   1   write enable
//   rs_ID        in   5   read port A index
//   rt_ID        in   5   read port B index
//   rsdata_ID    out 32   read port A data
//   rtdata_ID    out 32   read port B data
//   wbdata       out 32   selected writeback value
//   wb_count     out 32   number of committed writes (wraps)
// ---------------------------------------------------------------------------
module wb_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] readdata_WB,
    input  logic [31:0] alu_WB,
    input  logic [4:0]  rd_WB,
    input  logic        memtoreg_WB,
    input  logic        regwrite_WB,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    output logic [31:0] rsdata_ID,
    output logic [31:0] rtdata_ID,
    output logic [31:0] wbdata,
    output logic [31:0] wb_count
);

    // Entry 0 is never written (commit excludes rd_WB == 0), so it stays zero.
    // The array is flop-based because every entry must clear asynchronously.
    logic [31:0] rf_reg [32];
    logic [31:0] wb_count_reg;
    logic        commit;

    assign wbdata = memtoreg_WB ? readdata_WB : alu_WB;

    // Gating with rst also disables the bypass while reset is asserted.
    assign commit = rst && regwrite_WB && (rd_WB != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_reg[i] <= '0;
            end
            wb_count_reg <= '0;
        end else if (commit) begin
            rf_reg[rd_WB] <= wbdata;
            wb_count_reg  <= wb_count_reg + 32'd1;
        end
    end

    assign wb_count = wb_count_reg;

    // Two identical read ports; index 0 is port A (rs), index 1 is port B (rt).
    logic [4:0]  rd_idx  [2];
    logic [31:0] rd_data [2];

    assign rd_idx[0] = rs_ID;
    assign rd_idx[1] = rt_ID;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
            always_comb begin
                rd_data[gi] = '0;
                if (!rst || rd_idx[gi] == 5'd0) begin
                    rd_data[gi] = '0;
                end else if (commit && rd_idx[gi] == rd_WB) begin
                    // Write-through: the value being committed this cycle.
                    rd_data[gi] = wbdata;
                end else begin
                    rd_data[gi] = rf_reg[rd_idx[gi]];
                end
            end
        end
    endgenerate

    assign rsdata_ID = rd_data[0];
    assign rtdata_ID = rd_data[1];

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile -- self-checking bench for wb_regfile.
// A plain array + counter model is updated from the architectural rules;
// directed scenarios cover reset, write/read, bypass, register 0, async reset
// mid-run and counter wrap, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] readdata_WB;
    logic [31:0] alu_WB;
    logic [4:0]  rd_WB;
    logic        memtoreg_WB;
    logic        regwrite_WB;
    logic [4:0]  rs_ID;
    logic [4:0]  rt_ID;
    logic [31:0] rsdata_ID;
    logic [31:0] rtdata_ID;
    logic [31:0] wbdata;
    logic [31:0] wb_count;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] m_rf [32];
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .readdata_WB (readdata_WB),
        .alu_WB      (alu_WB),
        .rd_WB       (rd_WB),
        .memtoreg_WB (memtoreg_WB),
        .regwrite_WB (regwrite_WB),
        .rs_ID       (rs_ID),
        .rt_ID       (rt_ID),
        .rsdata_ID   (rsdata_ID),
        .rtdata_ID   (rtdata_ID),
        .wbdata      (wbdata),
        .wb_count    (wb_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", tag, got);
        end
    endtask

    function automatic logic [31:0] m_wbdata();
        return memtoreg_WB ? readdata_WB : alu_WB;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (!rst || idx == 5'd0) return 32'd0;
        if (regwrite_WB && rd_WB != 5'd0 && idx == rd_WB) return m_wbdata();
        return m_rf[idx];
    endfunction

    task automatic apply_rst(input logic v);
        rst = v;
        if (!v) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_cnt = 32'd0;
        end
    endtask

    // One rising edge; the model commits from the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst && regwrite_WB && rd_WB != 5'd0) begin
            m_rf[rd_WB] = m_wbdata();
            m_cnt       = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic check_outputs(input string tag);
        #1;
        check_eq({tag, ".rs"},    rsdata_ID, m_read(rs_ID));
        check_eq({tag, ".rt"},    rtdata_ID, m_read(rt_ID));
        check_eq({tag, ".wbd"},   wbdata,    m_wbdata());
        check_eq({tag, ".count"}, wb_count,  m_cnt);
    endtask

    task automatic write_reg(input logic [4:0] rd, input logic [31:0] val);
        regwrite_WB = 1'b1;
        memtoreg_WB = 1'b0;
        alu_WB      = val;
        rd_WB       = rd;
        tick();
        regwrite_WB = 1'b0;
    endtask

    initial begin
        readdata_WB = 32'h0;
        alu_WB      = 32'h1111_1111;
        rd_WB       = 5'd5;
        memtoreg_WB = 1'b0;
        regwrite_WB = 1'b1;
        rs_ID       = 5'd5;
        rt_ID       = 5'd5;
        apply_rst(1'b0);

        // Reset held: no bypass, no commit, wbdata still follows the mux.
        check_outputs("rst_hold");
        tick();
        tick();
        check_outputs("rst_hold2");
        regwrite_WB = 1'b0;
        apply_rst(1'b1);

        // Every register reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            tick();
            rs_ID = 5'(i);
            rt_ID = 5'(31 - i);
            #1;
            check_eq($sformatf("rst_rd.rs%0d", i), rsdata_ID, 32'd0);
            check_eq($sformatf("rst_rd.rt%0d", 31 - i), rtdata_ID, 32'd0);
        end
        check_eq("rst_rd.count", wb_count, 32'd0);

        // Write then read back.
        rs_ID = 5'd0;
        rt_ID = 5'd0;
        write_reg(5'd5, 32'h1234_5678);
        rs_ID = 5'd5;
        #1;
        check_eq("wr.rs5", rsdata_ID, 32'h1234_5678);
        check_eq("wr.count", wb_count, 32'd1);

        // Bypass on both ports from the load path.
        tick();
        regwrite_WB = 1'b1;
        memtoreg_WB = 1'b1;
        readdata_WB = 32'hDEAD_BEEF;
        alu_WB      = 32'h0BAD_0BAD;
        rd_WB       = 5'd7;
        rs_ID       = 5'd7;
        rt_ID       = 5'd7;
        #1;
        check_eq("byp.rs", rsdata_ID, 32'hDEAD_BEEF);
        check_eq("byp.rt", rtdata_ID, 32'hDEAD_BEEF);
        check_eq("byp.wbd", wbdata, 32'hDEAD_BEEF);
        tick();
        regwrite_WB = 1'b0;
        #1;
        check_eq("byp_after.rs", rsdata_ID, 32'hDEAD_BEEF);
        check_eq("byp_after.rt", rtdata_ID, 32'hDEAD_BEEF);
        check_eq("byp_after.count", wb_count, 32'd2);

        // Writes to register 0 are dropped and not counted.
        tick();
        regwrite_WB = 1'b1;
        memtoreg_WB = 1'b0;
        alu_WB      = 32'hFFFF_FFFF;
        rd_WB       = 5'd0;
        rs_ID       = 5'd0;
        rt_ID       = 5'd0;
        #1;
        check_eq("r0.rs", rsdata_ID, 32'd0);
        check_eq("r0.rt", rtdata_ID, 32'd0);
        tick();
        regwrite_WB = 1'b0;
        #1;
        check_eq("r0_after.rs", rsdata_ID, 32'd0);
        check_eq("r0_after.count", wb_count, 32'd2);

        // Async reset between edges.
        write_reg(5'd3, 32'hA5A5_A5A5);
        for (int i = 0; i < 6; i++) write_reg(5'(10 + i), $urandom);
        rs_ID = 5'd3;
        #1;
        check_eq("arst_pre.r3", rsdata_ID, 32'hA5A5_A5A5);
        check_eq("arst_pre.count", wb_count, 32'd9);
        regwrite_WB = 1'b1;
        memtoreg_WB = 1'b0;
        alu_WB      = 32'h5555_5555;
        rd_WB       = 5'd3;
        apply_rst(1'b0);
        #1;
        check_eq("arst.r3", rsdata_ID, 32'd0);
        check_eq("arst.count", wb_count, 32'd0);
        tick();
        check_outputs("arst_edge");
        regwrite_WB = 1'b0;
        apply_rst(1'b1);
        check_outputs("arst_rel");

        // Counter wrap, preloaded through the hierarchy.
        tick();
        dut.wb_count_reg = 32'hFFFF_FFFF;
        m_cnt            = 32'hFFFF_FFFF;
        #1;
        check_eq("wrap_pre.count", wb_count, 32'hFFFF_FFFF);
        write_reg(5'd9, 32'h0000_0001);
        #1;
        check_eq("wrap.count", wb_count, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            tick();
            if ($urandom_range(0, 49) == 0) apply_rst(1'b0);
            else if (!rst) apply_rst(1'b1);
            readdata_WB = $urandom;
            alu_WB      = $urandom;
            rd_WB       = 5'($urandom_range(0, 31));
            memtoreg_WB = 1'($urandom_range(0, 1));
            regwrite_WB = ($urandom_range(0, 3) != 0);
            rs_ID       = ($urandom_range(0, 3) == 0) ? rd_WB : 5'($urandom_range(0, 31));
            rt_ID       = ($urandom_range(0, 3) == 0) ? rs_ID : 5'($urandom_range(0, 31));
            check_outputs($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
